// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the program counter and the IF/ID pipeline register.
// Priority on every edge is reset, then redirect, then stall, then advance.
module if_stage #(
  parameter int          ADDR_W   = 16,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect_en,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  output logic [31:0]       if_id_inst,
  output logic [31:0]       if_id_pc_plus1,
  output logic              if_id_valid,
  output logic [31:0]       fetch_count
);

  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_inst;
  logic [31:0]       r_pc_plus1;
  logic              r_valid;
  logic [31:0]       r_fetch_count;

  logic [ADDR_W-1:0] w_pc_plus1;
  logic [31:0]       w_fetch_count_next;

  // PC+1 wraps naturally at 2^ADDR_W because it is kept at ADDR_W bits.
  assign w_pc_plus1         = r_pc + ADDR_W'(1);
  assign w_fetch_count_next = (r_fetch_count == 32'hFFFF_FFFF) ? r_fetch_count
                                                               : r_fetch_count + 32'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= ADDR_W'(RESET_PC);
      r_inst        <= '0;
      r_pc_plus1    <= '0;
      r_valid       <= 1'b0;
      r_fetch_count <= '0;
    end else if (redirect_en) begin
      // Squash the wrong-path word; the target is fetched on the next edge.
      r_pc       <= redirect_pc;
      r_inst     <= '0;
      r_pc_plus1 <= '0;
      r_valid    <= 1'b0;
    end else if (!stall) begin
      r_pc          <= w_pc_plus1;
      r_inst        <= imem_data;
      r_pc_plus1    <= 32'(w_pc_plus1);
      r_valid       <= 1'b1;
      r_fetch_count <= w_fetch_count_next;
    end
  end

  assign imem_addr      = r_pc;
  assign if_id_inst     = r_inst;
  assign if_id_pc_plus1 = r_pc_plus1;
  assign if_id_valid    = r_valid;
  assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: a driver pushes expected IF/ID state per edge,
// a monitor pops and compares it after each rising edge.
module tb_if_stage;

  localparam int ADDR_W = 16;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst;
  logic              stall;
  logic              redirect_en;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic [31:0]       if_id_inst;
  logic [31:0]       if_id_pc_plus1;
  logic              if_id_valid;
  logic [31:0]       fetch_count;

  logic [31:0] mem [0:DEPTH-1];

  typedef struct {
    int          pc;
    logic [31:0] inst;
    logic [31:0] pp1;
    logic        valid;
    logic [31:0] cnt;
  } exp_t;

  exp_t expQ[$];

  int total = 0;
  int bad   = 0;

  // Reference model state, updated with plain arithmetic from the stage rules.
  int          mPc;
  logic [31:0] mInst;
  logic [31:0] mPp1;
  logic        mValid;
  logic [31:0] mCnt;

  if_stage #(.ADDR_W(ADDR_W), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_id_inst     (if_id_inst),
    .if_id_pc_plus1 (if_id_pc_plus1),
    .if_id_valid    (if_id_valid),
    .fetch_count    (fetch_count)
  );

  assign imem_data = mem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Drive one edge worth of inputs at the falling edge and record what must follow.
  task automatic applyStimulus(input logic r, input logic s, input logic re, input int rpc);
    exp_t e;
    @(negedge clk);
    rst         = r;
    stall       = s;
    redirect_en = re;
    redirect_pc = ADDR_W'(rpc);
    #1;
    if (mPc >= 0) checkOutput("addr_pre_edge", 32'(imem_addr), 32'(mPc));
    if (r) begin
      mPc = 0; mInst = 0; mPp1 = 0; mValid = 0; mCnt = 0;
    end else if (re) begin
      mPc = rpc % DEPTH; mInst = 0; mPp1 = 0; mValid = 0;
    end else if (!s) begin
      mInst  = mem[mPc];
      mPc    = (mPc + 1) % DEPTH;
      mPp1   = 32'(mPc);
      mValid = 1'b1;
      if (mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 1;
    end
    e.pc = mPc; e.inst = mInst; e.pp1 = mPp1; e.valid = mValid; e.cnt = mCnt;
    expQ.push_back(e);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every rising edge after a stimulus has been issued must match the model.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() != 0) begin
        e = expQ.pop_front();
        checkOutput("imem_addr",   32'(imem_addr),   32'(e.pc));
        checkOutput("if_id_inst",  if_id_inst,       e.inst);
        checkOutput("pc_plus1",    if_id_pc_plus1,   e.pp1);
        checkOutput("if_id_valid", 32'(if_id_valid), 32'(e.valid));
        checkOutput("fetch_count", fetch_count,      e.cnt);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'hAC1403E8;
    mem[1] = 32'hAC1203E9;
    mem[2] = 32'hAC1603EA;
    mem[5] = 32'h0000_0000;
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    mPc = -1; mInst = 0; mPp1 = 0; mValid = 0; mCnt = 0;

    applyStimulus(1, 0, 0, 0);
    settle();
    checkOutput("reset_valid", 32'(if_id_valid), 32'd0);
    checkOutput("reset_count", fetch_count, 32'd0);

    // Three free-running fetches from address 0.
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0);
    settle();
    checkOutput("run3_inst",  if_id_inst,      32'hAC1603EA);
    checkOutput("run3_pp1",   if_id_pc_plus1,  32'd3);
    checkOutput("run3_count", fetch_count,     32'd3);
    checkOutput("run3_addr",  32'(imem_addr),  32'd3);

    // Stall two edges at PC=7, then resume with word 7.
    while (mPc != 7) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    settle();
    checkOutput("stall_addr",  32'(imem_addr), 32'd7);
    checkOutput("stall_count", fetch_count,    32'd7);
    applyStimulus(0, 0, 0, 0);
    settle();
    checkOutput("resume_inst", if_id_inst, mem[7]);

    // Redirect from PC=17 to 6: one bubble, then word 6.
    while (mPc != 17) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 1, 6);
    settle();
    checkOutput("redir_valid", 32'(if_id_valid), 32'd0);
    checkOutput("redir_inst",  if_id_inst,       32'd0);
    checkOutput("redir_addr",  32'(imem_addr),   32'd6);
    applyStimulus(0, 0, 0, 0);
    settle();
    checkOutput("redir_next_inst", if_id_inst,     mem[6]);
    checkOutput("redir_next_pp1",  if_id_pc_plus1, 32'd7);

    // Redirect wins over a simultaneous stall.
    applyStimulus(0, 1, 1, 11);
    settle();
    checkOutput("redir_stall_addr",  32'(imem_addr),   32'd11);
    checkOutput("redir_stall_valid", 32'(if_id_valid), 32'd0);

    // PC wraps from the top of the address space.
    applyStimulus(0, 0, 1, 16'hFFFF);
    applyStimulus(0, 0, 0, 0);
    settle();
    checkOutput("wrap_addr",  32'(imem_addr),   32'd0);
    checkOutput("wrap_pp1",   if_id_pc_plus1,   32'd0);
    checkOutput("wrap_valid", 32'(if_id_valid), 32'd1);

    // Reset during a stall at PC=9 clears everything.
    while (mPc != 9) applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(1, 1, 0, 0);
    settle();
    checkOutput("rst_stall_addr",  32'(imem_addr),   32'd0);
    checkOutput("rst_stall_inst",  if_id_inst,       32'd0);
    checkOutput("rst_stall_pp1",   if_id_pc_plus1,   32'd0);
    checkOutput("rst_stall_valid", 32'(if_id_valid), 32'd0);
    checkOutput("rst_stall_count", fetch_count,      32'd0);
    applyStimulus(0, 0, 0, 0);
    settle();
    checkOutput("post_rst_inst", if_id_inst, 32'hAC1403E8);

    // Random mix of advance, stall, redirect and occasional reset.
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)
        applyStimulus(1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, int'($urandom_range(0, DEPTH - 1)));
      else if (r < 14)
        applyStimulus(0, $urandom_range(0, 1) == 1, 1,
                      ($urandom_range(0, 3) == 0) ? DEPTH - 1 - int'($urandom_range(0, 2))
                                                  : int'($urandom_range(0, DEPTH - 1)));
      else if (r < 40)
        applyStimulus(0, 1, 0, int'($urandom_range(0, DEPTH - 1)));
      else
        applyStimulus(0, 0, 0, int'($urandom_range(0, DEPTH - 1)));
    end

    settle();
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_drain actual=%0d required=0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: ADDR_W, default 16; width of the word-indexed program counter and instruction-memory address.
REQ-002 Parameter: RESET_PC, default 0; word index loaded into PC on reset.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: stall  input  1  hold PC and IF/ID register (load-use hazard from decode).
REQ-006 Port: redirect_en  input  1  taken branch or jump resolved downstream; load redirect_pc and squash the IF/ID register.
REQ-007 Port: redirect_pc  input  ADDR_W  word index of the branch or jump target.
REQ-008 Port: imem_addr  output  ADDR_W  word address to instruction memory; equals current PC, combinational.
REQ-009 Port: imem_data  input  32  instruction word at imem_addr, combinational read, valid in the same cycle.
REQ-010 Port: if_id_inst  output  32  registered instruction presented to decode.
REQ-011 Port: if_id_pc_plus1  output  32  registered PC+1 of if_id_inst, zero-extended from ADDR_W.
REQ-012 Port: if_id_valid  output  1  if_id_inst is a real fetched instruction (0 = bubble).
REQ-013 Port: fetch_count  output  32  number of instructions latched with if_id_valid=1 since reset.

Function
REQ-014 Each rising edge SHALL apply exactly one action, by priority: rst > redirect_en > stall > advance.
REQ-015 Advance: PC <= PC+1; if_id_inst <= imem_data; if_id_pc_plus1 <= PC+1; if_id_valid <= 1; fetch_count <= fetch_count+1.
REQ-016 Stall (redirect_en=0): PC, if_id_inst, if_id_pc_plus1, if_id_valid and fetch_count SHALL hold.
REQ-017 Redirect: PC <= redirect_pc; if_id_inst <= 0 (nop); if_id_pc_plus1 <= 0; if_id_valid <= 0; fetch_count holds.
REQ-018 Redirect asserted with stall SHALL be treated as redirect; the stall is ignored that cycle.
REQ-019 Instruction after redirect: the word at redirect_pc SHALL reach IF/ID on the edge following the redirect edge (one bubble cycle).
REQ-020 PC arithmetic SHALL be modulo 2^ADDR_W; PC = 2^ADDR_W-1 advances to 0, and if_id_pc_plus1 is then 0.
REQ-021 fetch_count SHALL saturate at 0xFFFFFFFF and not wrap.
REQ-022 imem_addr SHALL follow PC with zero combinational dependence on stall or redirect_en.
REQ-023 The block SHALL perform no instruction decoding; all-zero words are passed through as ordinary valid instructions.

Reset
REQ-024 With rst=1 at an edge: PC <= RESET_PC, if_id_inst <= 0, if_id_pc_plus1 <= 0, if_id_valid <= 0, fetch_count <= 0, regardless of stall and redirect_en.
REQ-025 Reset asserted mid-stall or mid-redirect SHALL discard the pending operation; no state survives.
REQ-026 First edge with rst=0 and no stall/redirect SHALL latch the word at RESET_PC into IF/ID.
REQ-027 Outputs SHALL be stable and defined throughout reset; no X on any output after the first reset edge.

Verification
REQ-028 Reset then 3 free-running cycles, imem[0]=0xAC1403E8, imem[1]=0xAC1203E9, imem[2]=0xAC1603EA -> IF/ID shows those words in order with pc_plus1 1,2,3, valid=1, fetch_count=3, imem_addr=3.
REQ-029 At PC=7, assert stall for 2 cycles -> IF/ID and imem_addr hold (imem_addr=7) for 2 edges, fetch_count unchanged, then resumes with word 7.
REQ-030 At PC=17, redirect_en=1, redirect_pc=6 -> next edge if_id_valid=0, if_id_inst=0, imem_addr=6; following edge IF/ID holds imem[6] with pc_plus1=7.
REQ-031 redirect_en=1 and stall=1 together, redirect_pc=11 -> redirect taken: imem_addr=11, if_id_valid=0.
REQ-032 PC preset by redirect to 0xFFFF (ADDR_W=16), advance -> imem_addr=0, if_id_pc_plus1=0, if_id_valid=1.
REQ-033 rst asserted for one edge while stall=1 at PC=9 -> PC=0, all IF/ID outputs 0, fetch_count=0.
